// File: rtl/nn_pkg.sv
// Shared definitions for the single-neuron pipeline: float32 width,
// the +0.0 encoding, default vector size / counter width and the
// input sequencer state type.
package nn_pkg;

    localparam int                FP_W    = 32;
    localparam logic [FP_W-1:0]   FP_ZERO = 32'h0000_0000;

    // Defaults shared with the neuron stage.
    localparam int                NN_N    = 6;
    localparam int                NN_CW   = 3;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT,
        DONE
    } seq_state_e;

endpackage

// File: rtl/nn_input_sequencer_if.sv
// Bus between the input sequencer and its environment: host-side buffer
// writes and go/done handshake, plus the neuron-side xi/counter/start/eoc
// stream. The master modport is the sequencer's view.
interface nn_input_sequencer_if
    import nn_pkg::*;
#(
    parameter int CW = NN_CW
);

    // host side
    logic            wr_en;
    logic [CW-1:0]   wr_addr;
    logic [FP_W-1:0] wr_data;
    logic            go;
    logic            busy;
    logic            done;
    logic [FP_W-1:0] result;
    logic            err;

    // neuron side
    logic [FP_W-1:0] xi;
    logic [CW-1:0]   counter;
    logic            start;
    logic            eoc;
    logic [FP_W-1:0] neuron_out;

    modport master (
        input  wr_en, wr_addr, wr_data, go, eoc, neuron_out,
        output xi, counter, start, busy, done, result, err
    );

    modport slave (
        output wr_en, wr_addr, wr_data, go, eoc, neuron_out,
        input  xi, counter, start, busy, done, result, err
    );

endinterface

// File: rtl/nn_input_buf.sv
// N x 32 input vector register file: synchronous clear, one write port,
// one combinational read port. Out-of-range read addresses return +0.0
// and out-of-range writes match no entry, so they are dropped.
module nn_input_buf
    import nn_pkg::*;
#(
    parameter int N  = NN_N,
    parameter int CW = NN_CW
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_addr,
    input  logic [FP_W-1:0] wr_data,
    input  logic [CW-1:0]   rd_addr,
    output logic [FP_W-1:0] rd_data
);

    logic [N-1:0][FP_W-1:0] entry_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : gen_entry
            logic [FP_W-1:0] entry_reg;

            // Each entry clears together with the others and loads only
            // when its own index is written.
            always_ff @(posedge clk) begin
                if (clr) begin
                    entry_reg <= FP_ZERO;
                end else if (wr_en && (wr_addr == CW'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_vec[gi] = entry_reg;
        end
    endgenerate

    // Index-compare read mux; anything past N-1 reads as +0.0.
    always_comb begin
        rd_data = FP_ZERO;
        for (int i = 0; i < N; i++) begin
            if (rd_addr == CW'(i)) begin
                rd_data = entry_vec[i];
            end
        end
    end

endmodule

// File: rtl/nn_input_sequencer.sv
// Input sequencer for the single-neuron ReLU stage. Buffers one N-element
// float32 vector, streams it to the neuron on go (counter 0..N+1, +0.0 past
// the end), waits SETTLE cycles at counter=N+1 before trusting the sticky
// eoc, then captures the neuron output and pulses done.
// Optional watchdog on the WAIT state: define NN_SEQ_TIMEOUT_EN.
module nn_input_sequencer
    import nn_pkg::*;
#(
    parameter int N      = NN_N,
    parameter int CW     = NN_CW,
    parameter int SETTLE = 2
`ifdef NN_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nn_input_sequencer_if.master bus
);

    localparam int            SW       = $clog2(SETTLE + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(N + 1);

    seq_state_e      state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [SW-1:0]   settle_reg, settle_next;
    logic [FP_W-1:0] result_reg, result_next;
    logic [FP_W-1:0] buf_rd;
    logic            buf_wr;

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int   WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0]   wd_reg, wd_next;
    logic            err_reg, err_next;
`endif

    // The vector is only writable while idle; a write coinciding with go
    // still lands before the first read of the stream.
    assign buf_wr = bus.wr_en && (state_reg == IDLE) && (bus.wr_addr < CW'(N));

    nn_input_buf #(
        .N  (N),
        .CW (CW)
    ) u_buf (
        .clk     (clk),
        .clr     (!rst_n),
        .wr_en   (buf_wr),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (cnt_reg),
        .rd_data (buf_rd)
    );

    // State and counter registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            settle_reg <= '0;
            result_reg <= FP_ZERO;
`ifdef NN_SEQ_TIMEOUT_EN
            wd_reg     <= '0;
            err_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            settle_reg <= settle_next;
            result_reg <= result_next;
`ifdef NN_SEQ_TIMEOUT_EN
            wd_reg     <= wd_next;
            err_reg    <= err_next;
`endif
        end
    end

    // Next-state logic. The result is captured on the edge into DONE so
    // it is already valid while done is high.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        settle_next = settle_reg;
        result_next = result_reg;
`ifdef NN_SEQ_TIMEOUT_EN
        wd_next     = wd_reg;
        err_next    = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.go) begin
                    state_next = STREAM;
                    cnt_next   = '0;
`ifdef NN_SEQ_TIMEOUT_EN
                    err_next   = 1'b0;
`endif
                end
            end
            STREAM: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next  = WAIT;
                    settle_next = '0;
`ifdef NN_SEQ_TIMEOUT_EN
                    wd_next     = '0;
`endif
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT: begin
                if (settle_reg < SW'(SETTLE)) begin
                    settle_next = settle_reg + SW'(1);
                end
                // eoc is sticky from the previous run, so it only counts
                // once the neuron has had SETTLE cycles at counter=N+1.
                if ((settle_reg == SW'(SETTLE)) && bus.eoc) begin
                    state_next  = DONE;
                    result_next = bus.neuron_out;
                end
`ifdef NN_SEQ_TIMEOUT_EN
                else if (wd_reg == WW'(TIMEOUT - 1)) begin
                    state_next  = DONE;
                    result_next = FP_ZERO;
                    err_next    = 1'b1;
                end else begin
                    wd_next = wd_reg + WW'(1);
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        bus.start   = (state_reg == STREAM) || (state_reg == WAIT);
        bus.busy    = (state_reg != IDLE);
        bus.done    = (state_reg == DONE);
        bus.result  = result_reg;
        bus.counter = '0;
        bus.xi      = FP_ZERO;
        if (state_reg == STREAM) begin
            bus.counter = cnt_reg;
            bus.xi      = buf_rd;
        end else if (state_reg == WAIT) begin
            bus.counter = LAST_CNT;
        end
`ifdef NN_SEQ_TIMEOUT_EN
        bus.err = err_reg;
`else
        bus.err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_nn_input_sequencer.sv
// Testbench for nn_input_sequencer: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// time-offset model of a run (offset t after the go edge).
module tb_nn_input_sequencer;

    localparam int N       = 6;
    localparam int CW      = 3;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    nn_input_sequencer_if #(.CW(CW)) bus ();

    nn_input_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_runs   = 0;
    bit chk_en   = 1'b0;

    logic [31:0] xi_seen [N+2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is described by its offset t from the go edge: offsets
    // 0..N+1 stream the vector, later offsets wait; done follows the first
    // edge at offset >= N+2+SETTLE where eoc is seen high.
    logic [31:0] m_buf [N];
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_t      = 0;
    logic [31:0] m_result = '0;
    bit          m_err    = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_buf[i] = '0;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_t      = 0;
            m_result = '0;
            m_err    = 1'b0;
        end else if (m_done) begin
            m_done   = 1'b0;
            m_active = 1'b0;
        end else if (!m_active) begin
            if (bus.wr_en && (int'(bus.wr_addr) < N)) m_buf[bus.wr_addr] = bus.wr_data;
            if (bus.go) begin
                m_active = 1'b1;
                m_t      = 0;
                m_err    = 1'b0;
            end
        end else begin
            if ((m_t >= N + 2 + SETTLE) && bus.eoc) begin
                m_done   = 1'b1;
                m_result = bus.neuron_out;
            end
`ifdef NN_SEQ_TIMEOUT_EN
            else if (m_t - (N + 2) == TIMEOUT - 1) begin
                m_done   = 1'b1;
                m_result = '0;
                m_err    = 1'b1;
            end
`endif
            else begin
                m_t++;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_start;
            logic [31:0] e_cnt;
            logic [31:0] e_xi;
            e_start = m_active && !m_done;
            e_cnt   = 0;
            e_xi    = '0;
            if (e_start) begin
                e_cnt = (m_t <= N + 1) ? m_t : N + 1;
                if (m_t < N) e_xi = m_buf[m_t];
            end
            check("busy",    32'(bus.busy),    32'(m_active));
            check("done",    32'(bus.done),    32'(m_done));
            check("start",   32'(bus.start),   32'(e_start));
            check("counter", 32'(bus.counter), e_cnt);
            check("xi",      bus.xi,           e_xi);
            check("result",  bus.result,       m_result);
            check("err",     32'(bus.err),     32'(m_err));
            if (bus.done === 1'b1) begin
                n_runs++;
                $display("run %0d: result=%h err=%b", n_runs, bus.result, bus.err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_buf(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Pulses go (optionally with a same-cycle write), then follows the run
    // until done. cyc is the offset of the done cycle from the go edge.
    // inject_at: offset at which go + write(addr 2) are pulsed mid-run.
    // eoc_at: offset after which eoc is raised.
    task automatic go_run(input int inject_at, input int eoc_at, input bit do_wr,
                          input logic [2:0] wa, input logic [31:0] wd,
                          output int cyc, output logic err0);
        @(negedge clk);
        bus.go = 1'b1;
        if (do_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = wa;
            bus.wr_data = wd;
        end
        @(negedge clk);
        bus.go    = 1'b0;
        bus.wr_en = 1'b0;
        cyc  = 0;
        err0 = bus.err;
        while ((cyc < 300) && (bus.done !== 1'b1)) begin
            if (cyc <= N + 1) xi_seen[cyc] = bus.xi;
            if (cyc == eoc_at) bus.eoc = 1'b1;
            if (cyc == inject_at) begin
                bus.go      = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = 3'd2;
                bus.wr_data = 32'h1234_5678;
            end else begin
                bus.go    = 1'b0;
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.go    = 1'b0;
        bus.wr_en = 1'b0;
        if (cyc >= 300) check("done_within_bound", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int          cyc;
        logic        err0;
        logic [31:0] vec [N];
        vec[0] = 32'h3F80_0000; vec[1] = 32'h4000_0000; vec[2] = 32'h4040_0000;
        vec[3] = 32'h3F00_0000; vec[4] = 32'hBF80_0000; vec[5] = 32'h4080_0000;

        // stale eoc held high from reset onward
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.go = 0;
        bus.eoc = 1'b1; bus.neuron_out = 32'h4120_0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_start",   32'(bus.start),   32'd0);
        check("rst_counter", 32'(bus.counter), 32'd0);
        check("rst_xi",      bus.xi,           32'd0);
        check("rst_result",  bus.result,       32'd0);
        check("rst_err",     32'(bus.err),     32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // normal run, with an out-of-range write that must be dropped
        for (int i = 0; i < N; i++) write_buf(3'(i), vec[i]);
        write_buf(3'd6, 32'hDEAD_BEEF);
        go_run(-1, -1, 1'b0, 3'd0, 32'h0, cyc, err0);
        check("normal_latency", 32'(cyc), 32'd11);
        check("normal_result",  bus.result, 32'h4120_0000);
        check("normal_xi0",     xi_seen[0], 32'h3F80_0000);
        check("normal_xi3",     xi_seen[3], 32'h3F00_0000);
        check("normal_xi6",     xi_seen[6], 32'h0);

        // go + write mid-stream are ignored
        bus.neuron_out = 32'h4000_0000;
        go_run(2, -1, 1'b0, 3'd0, 32'h0, cyc, err0);
        check("inject_latency", 32'(cyc), 32'd11);
        go_run(-1, -1, 1'b0, 3'd0, 32'h0, cyc, err0);
        check("inject_buf2", xi_seen[2], 32'h4040_0000);

        // write and go together: stream sees the new entry
        go_run(-1, -1, 1'b1, 3'd0, 32'hAAAA_5555, cyc, err0);
        check("wrgo_xi0", xi_seen[0], 32'hAAAA_5555);

        // late eoc: raised after offset 15 -> done at offset 16
        bus.eoc = 1'b0;
        bus.neuron_out = 32'h40A0_0000;
        go_run(-1, 15, 1'b0, 3'd0, 32'h0, cyc, err0);
        check("late_eoc_latency", 32'(cyc), 32'd16);
        check("late_eoc_result",  bus.result, 32'h40A0_0000);

        // reset mid-run at counter 3
        bus.eoc = 1'b1;
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        cyc = 0;
        while ((bus.counter !== 3'd3) && (cyc < 20)) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_reach_cnt3", 32'(bus.counter), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_start", 32'(bus.start), 32'd0);
        check("midrst_busy",  32'(bus.busy),  32'd0);
        check("midrst_done",  32'(bus.done),  32'd0);
        rst_n = 1'b1;
        go_run(-1, -1, 1'b0, 3'd0, 32'h0, cyc, err0);
        check("midrst_latency", 32'(cyc), 32'd11);
        for (int i = 0; i < N; i++) check("midrst_buf_zero", xi_seen[i], 32'h0);

`ifdef NN_SEQ_TIMEOUT_EN
        // watchdog: eoc never comes
        bus.eoc = 1'b0;
        bus.neuron_out = 32'h4120_0000;
        go_run(-1, -1, 1'b0, 3'd0, 32'h0, cyc, err0);
        check("timeout_latency", 32'(cyc), 32'(N + 2 + TIMEOUT));
        check("timeout_result",  bus.result, 32'h0);
        check("timeout_err",     32'(bus.err), 32'd1);
        bus.eoc = 1'b1;
        go_run(-1, -1, 1'b0, 3'd0, 32'h0, cyc, err0);
        check("timeout_err_cleared", 32'(err0), 32'd0);
        check("after_timeout_latency", 32'(cyc), 32'd11);
`endif

        // randomized phase
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst_n          = ($urandom_range(0, 199) != 0);
            bus.wr_en      = 1'($urandom_range(0, 1));
            bus.wr_addr    = 3'($urandom_range(0, 7));
            bus.wr_data    = $urandom;
            bus.go         = ($urandom_range(0, 5) == 0);
            bus.eoc        = ($urandom_range(0, 2) == 0);
            bus.neuron_out = $urandom;
        end
        @(negedge clk);
        rst_n = 1'b1; bus.wr_en = 0; bus.go = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
